// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU32 among NREQ valid/ready requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [32*NREQ-1:0] req_a,
    input  logic [32*NREQ-1:0] req_b,
    input  logic [3*NREQ-1:0] req_s,
    input  logic [NREQ-1:0]   req_cin,
    output logic [31:0]       alu_a,
    output logic [31:0]       alu_b,
    output logic [2:0]        alu_s,
    output logic              alu_cin,
    input  logic [31:0]       alu_f,
    input  logic              alu_cout,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [31:0]       rsp_f,
    output logic              rsp_cout
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state;
    logic [IDW-1:0] ptr, win;
    logic found;
    logic [31:0] sel_a, sel_b;
    logic [2:0] sel_s;
    logic sel_cin;

    // Indices above the pointer take precedence over those at or below it; the later pass overwrites.
    always_comb begin
        win = '0;
        found = 1'b0;
        for (int i = NREQ-1; i >= 0; i--)
            if (req_valid[i] && i <= int'(ptr)) begin win = IDW'(i); found = 1'b1; end
        for (int i = NREQ-1; i >= 0; i--)
            if (req_valid[i] && i > int'(ptr)) begin win = IDW'(i); found = 1'b1; end
    end

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        sel_s = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++)
            if (win == IDW'(i)) begin
                sel_a = req_a[32*i +: 32];
                sel_b = req_b[32*i +: 32];
                sel_s = req_s[3*i +: 3];
                sel_cin = req_cin[i];
            end
    end

    assign req_ready = (state == IDLE && found) ? NREQ'(1) << win : '0;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign ptr = IDW'(NREQ-1);
`else
    always_ff @(posedge clk)
        ptr <= rst ? IDW'(NREQ-1) : (state == IDLE && found) ? win : ptr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            alu_a <= '0;
            alu_b <= '0;
            alu_s <= '0;
            alu_cin <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id <= '0;
            rsp_f <= '0;
            rsp_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    alu_a <= sel_a;
                    alu_b <= sel_b;
                    alu_s <= sel_s;
                    alu_cin <= sel_cin;
                    rsp_id <= win;
                    state <= EXEC;
                end
                EXEC: begin
                    rsp_f <= alu_f;
                    rsp_cout <= alu_cout;
                    rsp_valid <= 1'b1;
                    state <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter against a behavioural ALU32 model.
module tb_alu_arbiter;
    localparam int NREQ = 4;
    localparam int IDW = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NREQ-1:0] req_valid = '0, req_ready;
    logic [32*NREQ-1:0] req_a = '0, req_b = '0;
    logic [3*NREQ-1:0] req_s = '0;
    logic [NREQ-1:0] req_cin = '0;
    logic [31:0] alu_a, alu_b, alu_f, rsp_f;
    logic [2:0] alu_s;
    logic alu_cin, alu_cout, rsp_valid, rsp_cout;
    logic rsp_ready = 1'b0;
    logic [IDW-1:0] rsp_id;
    int checks = 0;
    int failures = 0;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_s(req_s), .req_cin(req_cin),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_f(rsp_f), .rsp_cout(rsp_cout)
    );

    always #5 clk = ~clk;

    always_comb begin
        {alu_cout, alu_f} = 33'd0;
        case (alu_s)
            3'd1: {alu_cout, alu_f} = {1'b0, alu_b} + {1'b0, ~alu_a} + 33'(alu_cin);
            3'd2: {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'(alu_cin);
            3'd3: {alu_cout, alu_f} = {1'b0, alu_a} + {1'b0, alu_b} + 33'(alu_cin);
            3'd4: alu_f = alu_a ^ alu_b;
            3'd5: alu_f = alu_a | alu_b;
            3'd6: alu_f = alu_a & alu_b;
            3'd7: alu_f = '1;
            default: alu_f = '0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] s, input logic cin);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_s[3*i +: 3] = s;
        req_cin[i] = cin;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
    endtask

    // Grants must be one-hot and only to a requester that is asking.
    always @(negedge clk)
        if (!rst) chk("grant_legal", 32'(((req_ready & ~req_valid) == '0) && $onehot0(req_ready)), 32'd1);

    int order [5];

    initial begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        step();
        step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_s", 32'(alu_s), 32'd0);
        chk("rst_alu_cin", 32'(alu_cin), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_f", rsp_f, 32'd0);
        chk("rst_rsp_cout", 32'(rsp_cout), 32'd0);
        rst = 1'b0;

        set_req(2, 32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0);
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1 chk("add_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        chk("add_exec_ready", 32'(req_ready), 32'd0);
        chk("add_alu_a", alu_a, 32'hFFFF_FFFF);
        chk("add_alu_s", 32'(alu_s), 32'd3);
        chk("add_rsp_early", 32'(rsp_valid), 32'd0);
        step();
        chk("add_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("add_rsp_f", rsp_f, 32'd0);
        chk("add_rsp_cout", 32'(rsp_cout), 32'd1);
        chk("add_rsp_id", 32'(rsp_id), 32'd2);
        step();
        chk("add_rsp_done", 32'(rsp_valid), 32'd0);

        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 16 + 1), 32'(i + 2), 3'd3, 1'b0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1 chk("rr_grant", 32'(req_ready), 32'd1 << order[k]);
            step();
            chk("rr_exec_ready", 32'(req_ready), 32'd0);
            chk("rr_alu_a", alu_a, 32'(order[k] * 16 + 1));
            step();
            chk("rr_resp_ready", 32'(req_ready), 32'd0);
            chk("rr_rsp_id", 32'(rsp_id), 32'(order[k]));
            chk("rr_rsp_f", rsp_f, 32'(order[k] * 17 + 3));
            step();
        end

        do_reset();
        set_req(1, 32'd3, 32'd5, 3'd2, 1'b1);
        req_valid = 4'b0010;
        rsp_ready = 1'b0;
        #1 chk("bp_grant", 32'(req_ready), 32'h2);
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_rsp_f", rsp_f, 32'hFFFF_FFFE);
            chk("bp_rsp_cout", 32'(rsp_cout), 32'd0);
            chk("bp_no_grant", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_no_grant", 32'(req_ready), 32'd0);
        step();
        chk("bp_rsp_cleared", 32'(rsp_valid), 32'd0);
        chk("bp_regrant", 32'(req_ready), 32'h2);

        do_reset();
        set_req(2, 32'hA5A5_0000, 32'h0000_5A5A, 3'd5, 1'b0);
        req_valid = 4'b0100;
        #1 chk("abort_grant", 32'(req_ready), 32'h4);
        step();
        rst = 1'b1;
        req_valid = '0;
        step();
        rst = 1'b0;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_alu_a", alu_a, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        req_valid = 4'b1001;
        #1 chk("abort_ptr_reset", 32'(req_ready), 32'h1);

        do_reset();
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        #1 chk("wd_grant0", 32'(req_ready), 32'h1);
        step();
        req_valid = 4'b1000;
        step();
        req_valid = 4'b1010;
        #1 chk("wd_resp_no_grant", 32'(req_ready), 32'd0);
        step();
        req_valid = 4'b1000;
        rsp_ready = 1'b1;
        #1 chk("wd_resp_hold", 32'(req_ready), 32'd0);
        step();
        chk("wd_grant3", 32'(req_ready), 32'h8);
        step();
        req_valid = '0;
        step();
        chk("wd_rsp_id", 32'(rsp_id), 32'd3);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
